conv33_ctrl: RTL
================

Name: conv33_ctrl

Overview:
Sequencer for the 3x3 convolution datapath. It sweeps a valid (no-padding, stride-1) 3x3 window over an IMG_W x IMG_H input map for each of OUT_CH output channels. For each output pixel it:
- requests a window fetch from the line/window buffer,
- selects weights and bias by channel,
- pulses conv33_en into the calc unit,
- writes the registered result to the output map.

It sits between the top-level layer controller (start/done) and the window buffer, weight ROM, conv calc unit and output RAM.

Parameters:
- IMG_W, 28: input map width in pixels (>=3)
- IMG_H, 28: input map height in pixels (>=3)
- OUT_CH, 6: number of output channels processed sequentially (>=1)
- ADDR_WIDTH, 16: width of pix_addr and out_addr
- CH_WIDTH, 4: width of ch_sel; must satisfy 2^CH_WIDTH >= OUT_CH
- WIN_TIMEOUT, 255: max cycles to wait for win_ready; used only with CONV33_CTRL_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  1-cycle pulse; begins a layer run when idle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  1-cycle pulse at end of run
- win_req  out  1  1-cycle request to window buffer to load the window at pix_addr
- pix_addr  out  ADDR_WIDTH  top-left input pixel index = row*IMG_W + col
- win_ready  in  1  window buffer: 9 window taps valid and held until next win_req
- ch_sel  out  CH_WIDTH  output channel index, selects weight_0..8 and bias
- conv33_en  out  1  1-cycle enable to calc unit
- calc_valid  in  1  calc unit valid (registered result available)
- out_we  out  1  output RAM write enable
- out_addr  out  ADDR_WIDTH  output index = ch*OW*OH + row*OW + col, with OW=IMG_W-2, OH=IMG_H-2
- err  out  1  sticky timeout flag (only with macro; tied 0 otherwise)

Behaviour:
- Reset values:
  - All outputs 0.
  - Counters col, row and ch are 0.
  - FSM is in IDLE.
  - Reset mid-run aborts immediately to IDLE with no done pulse.
- FSM states:
  - IDLE: start=1 goes to FETCH. Counters are cleared and out_addr=0. busy goes 1 next cycle.
  - FETCH: win_req=1 for exactly one cycle, with pix_addr and ch_sel stable. Goes to WAITWIN.
  - WAITWIN: stays while win_ready=0. win_ready=1 goes to CALC. A win_ready high during FETCH itself is ignored; only WAITWIN samples it.
  - CALC: conv33_en=1 for exactly one cycle. Goes to WAITRES.
  - WAITRES: out_we = calc_valid, combinational in this state only, with out_addr stable. On calc_valid=1 the counters advance. Goes to FETCH, or to DONE after the last pixel of the last channel.
  - DONE: done=1 for one cycle and busy=0. Goes to IDLE.
- Counter order: col is innermost (0..OW-1), then row (0..OH-1), then ch (0..OUT_CH-1).
  - col wraps to 0 and increments row.
  - row wraps to 0 and increments ch.
  - out_addr increments by 1 per write.
  - pix_addr is recomputed registered from row/col, valid before FETCH.
- Minimum throughput is 4 cycles per output pixel (FETCH, WAITWIN, CALC, WAITRES). This assumes the calc unit's 1-cycle registered latency and win_ready asserted in the first WAITWIN cycle.
- Total writes per run = OUT_CH*OW*OH. Last out_addr = OUT_CH*OW*OH-1.
- start while busy is ignored. start in the DONE cycle is ignored.
- calc_valid outside WAITRES is ignored and produces no write.
- ch_sel is held constant from FETCH through WAITRES so weights and bias are stable across the conv33_en cycle.

Optional Feature:
CONV33_CTRL_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAITWIN.
  - If win_ready is not seen within WIN_TIMEOUT cycles, err is set (sticky until rst or next accepted start), the run aborts, and the FSM goes to DONE (done pulses).
  - The counter clears on each entry to WAITWIN.
- Undefined: no counter, err tied 0, WAITWIN waits indefinitely.

Test Plan:
1. IMG_W=4, IMG_H=4, OUT_CH=2, win_ready 1 cycle after win_req, calc_valid 1 cycle after conv33_en -> pix_addr sequence 0,1,4,5 per channel; ch_sel 0 then 1; out_addr 0..7; exactly 8 out_we; done pulse 32 cycles after first FETCH; busy low after.
2. Same config, win_ready delayed 5 cycles on the 3rd window -> conv33_en is not asserted until win_ready; no extra/missing writes; out_addr order unchanged.
3. start pulsed again mid-run and during DONE -> ignored; exactly 8 writes; one done pulse.
4. rst asserted during WAITRES of pixel 2 -> all outputs 0 on the same edge; no done; a subsequent start restarts from pix_addr 0, out_addr 0.
5. Spurious calc_valid in IDLE and FETCH -> out_we stays 0.
6. With CONV33_CTRL_TIMEOUT_EN, WIN_TIMEOUT=8, win_ready held 0 -> err=1 and done pulse about 9 cycles after win_req; err clears on next start. Without the macro, the FSM stays in WAITWIN and err=0.

Source files
------------

// File: rtl/conv33_ctrl.sv
// Sequencer for the 3x3 valid convolution: sweeps col/row/channel, handshakes with
// the window buffer and calc unit, and writes results. Optional macro: CONV33_CTRL_TIMEOUT_EN.
module conv33_ctrl #(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int OUT_CH      = 6,
    parameter int ADDR_WIDTH  = 16,
    parameter int CH_WIDTH    = 4,
    parameter int WIN_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  win_req_o,
    output logic [ADDR_WIDTH-1:0] pix_addr_o,
    input  logic                  win_ready_i,
    output logic [CH_WIDTH-1:0]   ch_sel_o,
    output logic                  conv33_en_o,
    input  logic                  calc_valid_i,
    output logic                  out_we_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic                  err_o
);

    localparam int OW    = IMG_W - 2;
    localparam int OH    = IMG_H - 2;
    localparam int COL_W = $clog2(OW + 1);
    localparam int ROW_W = $clog2(OH + 1);

    localparam logic [COL_W-1:0]      COL_LAST = COL_W'(OW - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(OH - 1);
    localparam logic [CH_WIDTH-1:0]   CH_LAST  = CH_WIDTH'(OUT_CH - 1);
    // Last window of a row to first window of the next row skips the two border columns.
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAITWIN,
        S_CALC,
        S_WAITRES,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [CH_WIDTH-1:0]   ch_q, ch_d;
    logic [ADDR_WIDTH-1:0] pix_q, pix_d;
    logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
    logic                  timeout;

`ifdef CONV33_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(WIN_TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;

    assign timeout = (to_cnt_q == TO_W'(WIN_TIMEOUT - 1));
    assign err_o   = err_q;

    // Counter is cleared in FETCH so every WAITWIN entry starts from zero.
    always_comb begin
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        if (state_q == S_FETCH) begin
            to_cnt_d = '0;
        end else if (state_q == S_WAITWIN) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (state_q == S_IDLE && start_i) begin
            err_d = 1'b0;
        end else if (state_q == S_WAITWIN && !win_ready_i && timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        ch_d        = ch_q;
        pix_d       = pix_q;
        oaddr_d     = oaddr_q;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        win_req_o   = 1'b0;
        conv33_en_o = 1'b0;
        out_we_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    col_d   = '0;
                    row_d   = '0;
                    ch_d    = '0;
                    pix_d   = '0;
                    oaddr_d = '0;
                end
            end
            S_FETCH: begin
                busy_o    = 1'b1;
                win_req_o = 1'b1;
                state_d   = S_WAITWIN;
            end
            S_WAITWIN: begin
                busy_o = 1'b1;
                if (win_ready_i) begin
                    state_d = S_CALC;
                end else if (timeout) begin
                    state_d = S_DONE;
                end
            end
            S_CALC: begin
                busy_o      = 1'b1;
                conv33_en_o = 1'b1;
                state_d     = S_WAITRES;
            end
            S_WAITRES: begin
                busy_o   = 1'b1;
                out_we_o = calc_valid_i;
                if (calc_valid_i) begin
                    oaddr_d = oaddr_q + 1'b1;
                    state_d = S_FETCH;
                    if (col_q != COL_LAST) begin
                        col_d = col_q + 1'b1;
                        pix_d = pix_q + 1'b1;
                    end else begin
                        col_d = '0;
                        if (row_q != ROW_LAST) begin
                            row_d = row_q + 1'b1;
                            pix_d = pix_q + ROW_STEP;
                        end else begin
                            row_d = '0;
                            pix_d = '0;
                            if (ch_q != CH_LAST) begin
                                ch_d = ch_q + 1'b1;
                            end else begin
                                ch_d    = '0;
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            pix_q   <= '0;
            oaddr_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ch_q    <= ch_d;
            pix_q   <= pix_d;
            oaddr_q <= oaddr_d;
        end
    end

    assign pix_addr_o = pix_q;
    assign ch_sel_o   = ch_q;
    assign out_addr_o = oaddr_q;

endmodule
